// File: rtl/multi_channel_frequency_manager.sv
// Multi-channel pixel frequency manager: taps CHANNELS pixels, bins their periods into F0/F1/unknown, dumps results over a register-write handshake.
// Optional macro FREQ_MANAGER_UNKNOWN_EN adds the unknown-period accumulator (3 registers per channel instead of 2).
module multi_channel_frequency_manager #(
  parameter int CHANNELS = 3,
  parameter int DATA_WIDTH = 8,
  parameter int INDEX_WIDTH = 12,
  parameter int DARK_PIXELS = 16,
  parameter int LINE_PIXELS = 1040,
  parameter logic [CHANNELS*INDEX_WIDTH-1:0] PIXEL_INDICES = {12'd1023, 12'd511, 12'd63},
  parameter logic [CHANNELS*32-1:0] F0_PERIODS = {32'd4000, 32'd6667, 32'd10000},
  parameter logic [CHANNELS*32-1:0] F1_PERIODS = {32'd3333, 32'd5000, 32'd10000},
  parameter int DEVIATION = 30,
  parameter int THRESHOLD = 100
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  pixel_valid,
  input  logic                  line_start,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  output logic [1:0]            register_operation,
  output logic [7:0]            register_number,
  output logic [31:0]           register_write,
  input  logic                  register_ack,
  output logic                  irq,
  output logic                  busy,
  output logic [1:0]            state_dbg
);

`ifdef FREQ_MANAGER_UNKNOWN_EN
  localparam int R = 3;
`else
  localparam int R = 2;
`endif
  localparam int NREG = CHANNELS * R;
  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [31:0] SAT = '1;

  // Register handshake: a write (operation=2) is held until register_ack is
  // seen on the second or later cycle of that write; the next one follows
  // on the cycle after that ack.
  typedef enum logic [1:0] {IDLE, RUN, DUMP, DONE} state_t;
  state_t state;
  assign state_dbg = state;

  logic [INDEX_WIDTH-1:0] pixel_count;
  logic [INDEX_WIDTH-1:0] pixel_pos;
  logic [CHANNELS-1:0]    sample, sample_prev, edge_q, armed;
  logic [CHANNELS-1:0]    in_f0, in_f1;
  logic [31:0]            period [CHANNELS];
  logic [31:0]            f0_acc [CHANNELS];
  logic [31:0]            f1_acc [CHANNELS];
`ifdef FREQ_MANAGER_UNKNOWN_EN
  logic [31:0]            unk_acc [CHANNELS];
`endif
  logic [31:0]            dump_val [NREG];
  logic [IW-1:0]          reg_idx;
  logic                   write_seen;

  function automatic logic [32:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[32] ? (33'd0 - d) : d;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? SAT : s[31:0];
  endfunction

  // A line_start beat is pixel 0 regardless of the running count.
  assign pixel_pos = line_start ? '0 : pixel_count;

  always_comb begin
    in_f0 = '0;
    in_f1 = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      in_f0[k] = (period[k] != SAT) && (abs_diff(period[k], F0_PERIODS[k*32 +: 32]) <= 33'(DEVIATION));
      in_f1[k] = (period[k] != SAT) && (abs_diff(period[k], F1_PERIODS[k*32 +: 32]) <= 33'(DEVIATION));
    end
  end

  always_comb begin
    for (int i = 0; i < NREG; i++) dump_val[i] = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      dump_val[k*R]     = f0_acc[k];
      dump_val[k*R + 1] = f1_acc[k];
`ifdef FREQ_MANAGER_UNKNOWN_EN
      dump_val[k*R + 2] = unk_acc[k];
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= IDLE;
      pixel_count        <= '0;
      sample             <= '0;
      sample_prev        <= '0;
      edge_q             <= '0;
      armed              <= '0;
      reg_idx            <= '0;
      write_seen         <= 1'b0;
      register_operation <= 2'd0;
      register_number    <= 8'd0;
      register_write     <= 32'd0;
      irq                <= 1'b0;
      busy               <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        period[k] <= '0;
        f0_acc[k] <= '0;
        f1_acc[k] <= '0;
`ifdef FREQ_MANAGER_UNKNOWN_EN
        unk_acc[k] <= '0;
`endif
      end
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= RUN;
            busy        <= 1'b1;
            irq         <= 1'b0;
            pixel_count <= '0;
            sample      <= '0;
            sample_prev <= '0;
            edge_q      <= '0;
            armed       <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
              period[k] <= '0;
              f0_acc[k] <= '0;
              f1_acc[k] <= '0;
`ifdef FREQ_MANAGER_UNKNOWN_EN
              unk_acc[k] <= '0;
`endif
            end
          end else if (clear && state == DONE) begin
            state <= IDLE;
            irq   <= 1'b0;
          end
        end
        RUN: begin
          if (stop) begin
            // Anything still in the edge pipeline is dropped here.
            state              <= DUMP;
            reg_idx            <= '0;
            write_seen         <= 1'b0;
            register_operation <= 2'd2;
            register_number    <= 8'd1;
            register_write     <= dump_val[0];
          end else begin
            if (pixel_valid) begin
              if (line_start) pixel_count <= INDEX_WIDTH'(1);
              else if (pixel_count == INDEX_WIDTH'(LINE_PIXELS - 1)) pixel_count <= '0;
              else pixel_count <= pixel_count + 1'b1;
            end
            for (int k = 0; k < CHANNELS; k++) begin
              if (pixel_valid &&
                  pixel_pos == INDEX_WIDTH'(DARK_PIXELS) + PIXEL_INDICES[k*INDEX_WIDTH +: INDEX_WIDTH])
                sample[k] <= (data > DATA_WIDTH'(THRESHOLD));
              sample_prev[k] <= sample[k];
              edge_q[k]      <= sample[k] & ~sample_prev[k];
              if (edge_q[k]) begin
                period[k] <= 32'd1;
                armed[k]  <= 1'b1;
                if (armed[k]) begin
                  if (in_f0[k]) f0_acc[k] <= sat_add(f0_acc[k], period[k]);
                  else if (in_f1[k]) f1_acc[k] <= sat_add(f1_acc[k], period[k]);
`ifdef FREQ_MANAGER_UNKNOWN_EN
                  else unk_acc[k] <= sat_add(unk_acc[k], period[k]);
`endif
                end
              end else if (period[k] != SAT) begin
                period[k] <= period[k] + 32'd1;
              end
            end
          end
        end
        DUMP: begin
          if (register_ack && write_seen) begin
            if (reg_idx == IW'(NREG - 1)) begin
              state              <= DONE;
              busy               <= 1'b0;
              irq                <= 1'b1;
              register_operation <= 2'd0;
              register_number    <= 8'd0;
              register_write     <= 32'd0;
            end else begin
              reg_idx         <= reg_idx + 1'b1;
              register_number <= register_number + 8'd1;
              register_write  <= dump_val[reg_idx + 1'b1];
              write_seen      <= 1'b0;
            end
          end else begin
            write_seen <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
